// File: rtl/tile_dispatcher.sv
// Tile buffer between an upstream writer and the accumulator: fills n tiles,
// streams them out with valid/ready, then waits for the accumulator to finish.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | waiting for start; checks num_input_tiles
// S_FILL   | accepting n tiles from upstream into the buffer
// S_SEND   | offering buffered tiles to the accumulator in order
// S_WAIT_ACC | all tiles sent, waiting for act_load
module tile_dispatcher #(
  parameter int WIDTH           = 16,
  parameter int MAX_INPUT_TILES = 4,
  localparam int IW = (MAX_INPUT_TILES > 1) ? $clog2(MAX_INPUT_TILES) : 1,
  localparam int NW = $clog2(MAX_INPUT_TILES + 1),
  localparam int DW = 16 * WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    num_input_tiles,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          tile_valid,
  input  logic          tile_ready,
  output logic [DW-1:0] tile_data,
  output logic [IW-1:0] tile_idx,
  output logic          tile_last,
  input  logic          act_load,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SEND, S_WAIT_ACC} state_t;

  localparam logic [4:0] MAXT = 5'(MAX_INPUT_TILES);

  state_t        r_state;
  logic [IW-1:0] r_wr_ptr;
  logic [IW-1:0] r_rd_ptr;
  logic [NW-1:0] r_n;
  logic          r_done;
  logic          r_cfg_err;
  logic [DW-1:0] r_buf [MAX_INPUT_TILES];

  logic [IW-1:0] w_last_ptr;
  logic          w_send;

  assign w_last_ptr = IW'(r_n - NW'(1));
  assign w_send     = (r_state == S_SEND);

  // Buffer is deliberately not reset; outputs are gated so stale data never leaks.
  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) && wr_valid) begin
      r_buf[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_n       <= '0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_input_tiles == 4'd0) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_wr_ptr <= '0;
              r_rd_ptr <= '0;
              r_state  <= S_FILL;
              if ({1'b0, num_input_tiles} > MAXT) begin
                r_n       <= NW'(MAX_INPUT_TILES);
                r_cfg_err <= 1'b1;
              end else begin
                r_n <= NW'(num_input_tiles);
              end
            end
          end
        end
        S_FILL: begin
          if (wr_valid) begin
            if (r_wr_ptr == w_last_ptr) r_state <= S_SEND;
            else                        r_wr_ptr <= r_wr_ptr + IW'(1);
          end
        end
        S_SEND: begin
          if (tile_ready) begin
            if (r_rd_ptr == w_last_ptr) r_state <= S_WAIT_ACC;
            else                        r_rd_ptr <= r_rd_ptr + IW'(1);
          end
        end
        S_WAIT_ACC: begin
          if (act_load) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_ready   = (r_state == S_FILL);
  assign busy       = (r_state != S_IDLE);
  assign tile_valid = w_send;
  assign tile_data  = w_send ? r_buf[r_rd_ptr] : '0;
  assign tile_idx   = w_send ? r_rd_ptr : '0;
  assign tile_last  = w_send && (r_rd_ptr == w_last_ptr);
  assign done       = r_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_tile_dispatcher.sv
// Randomised bench for tile_dispatcher: each job is modelled as a queue of
// tiles whose length follows the clamp rules, and the outputs are compared per cycle.
module tb_tile_dispatcher;

  localparam int MAXT = 4;
  localparam int DW   = 256;

  logic          clk;
  logic          reset;
  logic          start;
  logic [3:0]    num_input_tiles;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          tile_valid;
  logic          tile_ready;
  logic [DW-1:0] tile_data;
  logic [1:0]    tile_idx;
  logic          tile_last;
  logic          act_load;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  tile_dispatcher #(.WIDTH(16), .MAX_INPUT_TILES(MAXT)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .num_input_tiles (num_input_tiles),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_data         (wr_data),
    .tile_valid      (tile_valid),
    .tile_ready      (tile_ready),
    .tile_data       (tile_data),
    .tile_idx        (tile_idx),
    .tile_last       (tile_last),
    .act_load        (act_load),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_tile();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full job; all expectations derive from num (clamped) and the tile queue.
  task automatic run_job(input int num, input int gap, input bit fixed_gap,
                         input int ready_pct, input logic [7:0] rpat, input int rpat_len,
                         input bit inject, input int acc_max);
    logic [DW-1:0] tiles[$];
    int  n_eff;
    int  rd;
    int  cyc;
    int  g;
    int  dly;
    bit  exp_err;
    bit  rdy;
    logic [1:0] exp_idx;
    n_eff   = (num > MAXT) ? MAXT : num;
    exp_err = (num == 0) || (num > MAXT);
    for (int i = 0; i < n_eff; i++) tiles.push_back(rnd_tile());

    check("idle_busy", DW'(busy), DW'(0));
    start = 1'b1;
    num_input_tiles = 4'(num);
    tick();
    start = 1'b0;
    num_input_tiles = 4'($urandom());
    check("cfg_err", DW'(cfg_err), DW'(exp_err));
    if (n_eff == 0) begin
      check("err_stay_idle", DW'(busy), DW'(0));
      check("err_wr_ready", DW'(wr_ready), DW'(0));
      tick();
      check("cfg_err_single", DW'(cfg_err), DW'(0));
      check("err_idle2", DW'(busy), DW'(0));
      return;
    end
    check("fill_busy", DW'(busy), DW'(1));

    for (int i = 0; i < n_eff; i++) begin
      g = fixed_gap ? gap : int'($urandom_range(0, gap));
      for (int k = 0; k < g; k++) begin
        wr_valid = 1'b0;
        wr_data  = rnd_tile();
        act_load = inject ? 1'($urandom()) : 1'b0;
        tick();
        check("gap_wr_ready", DW'(wr_ready), DW'(1));
        check("gap_tile_valid", DW'(tile_valid), DW'(0));
      end
      check("fill_wr_ready", DW'(wr_ready), DW'(1));
      check("fill_tile_data", tile_data, DW'(0));
      wr_valid = 1'b1;
      wr_data  = tiles[i];
      act_load = inject ? 1'($urandom()) : 1'b0;
      tick();
      if (i == 0) check("cfg_err_single", DW'(cfg_err), DW'(0));
    end

    check("send_wr_ready", DW'(wr_ready), DW'(0));
    check("latency_valid", DW'(tile_valid), DW'(1));
    rd  = 0;
    cyc = 0;
    while (rd < n_eff && cyc < 200) begin
      exp_idx = rd[1:0];
      check("tile_valid", DW'(tile_valid), DW'(1));
      check("tile_data", tile_data, tiles[rd]);
      check("tile_idx", DW'(tile_idx), DW'(exp_idx));
      check("tile_last", DW'(tile_last), DW'(rd == n_eff - 1));
      if (rpat_len > 0) rdy = rpat[cyc % rpat_len];
      else              rdy = (int'($urandom_range(0, 99)) < ready_pct);
      tile_ready = rdy;
      wr_valid   = 1'b1;
      wr_data    = rnd_tile();
      if (inject) begin
        start           = 1'($urandom());
        act_load        = 1'($urandom());
        num_input_tiles = 4'($urandom());
      end else begin
        act_load = 1'b0;
      end
      tick();
      if (rdy) rd++;
      cyc++;
    end
    if (cyc >= 200) check("send_timeout", DW'(0), DW'(1));
    tile_ready = 1'b0;
    start      = 1'b0;
    wr_valid   = 1'b0;
    act_load   = 1'b0;

    check("wait_valid", DW'(tile_valid), DW'(0));
    check("wait_last", DW'(tile_last), DW'(0));
    check("wait_idx", DW'(tile_idx), DW'(0));
    check("wait_data", tile_data, DW'(0));
    check("wait_busy", DW'(busy), DW'(1));
    dly = int'($urandom_range(0, acc_max));
    for (int k = 0; k < dly; k++) begin
      tick();
      check("wait_done", DW'(done), DW'(0));
      check("wait_busy2", DW'(busy), DW'(1));
    end
    act_load = 1'b1;
    tick();
    act_load = 1'b0;
    check("done_pulse", DW'(done), DW'(1));
    check("done_busy", DW'(busy), DW'(0));
    tick();
    check("done_single", DW'(done), DW'(0));
    check("idle_after", DW'(busy), DW'(0));
  endtask

  task automatic reset_mid_job();
    start = 1'b1;
    num_input_tiles = 4'd3;
    tick();
    start = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = rnd_tile();
      tick();
    end
    wr_valid   = 1'b0;
    tile_ready = 1'b1;
    tick();
    tile_ready = 1'b0;
    check("rst_pre_valid", DW'(tile_valid), DW'(1));
    check("rst_pre_idx", DW'(tile_idx), DW'(1));
    #2 reset = 1'b0;
    #1;
    check("rst_valid", DW'(tile_valid), DW'(0));
    check("rst_data", tile_data, DW'(0));
    check("rst_idx", DW'(tile_idx), DW'(0));
    check("rst_last", DW'(tile_last), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_wr_ready", DW'(wr_ready), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_cfg_err", DW'(cfg_err), DW'(0));
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_no_done", DW'(done), DW'(0));
      check("rst_no_valid", DW'(tile_valid), DW'(0));
    end
    reset = 1'b0;
    reset = 1'b1;
    run_job(1, 0, 1'b1, 100, 8'h00, 0, 1'b0, 0);
  endtask

  initial begin
    reset           = 1'b0;
    start           = 1'b0;
    num_input_tiles = 4'd0;
    wr_valid        = 1'b0;
    wr_data         = '0;
    tile_ready      = 1'b0;
    act_load        = 1'b0;
    #3;
    check("por_valid", DW'(tile_valid), DW'(0));
    check("por_data", tile_data, DW'(0));
    check("por_idx", DW'(tile_idx), DW'(0));
    check("por_last", DW'(tile_last), DW'(0));
    check("por_busy", DW'(busy), DW'(0));
    check("por_wr_ready", DW'(wr_ready), DW'(0));
    check("por_done", DW'(done), DW'(0));
    check("por_cfg_err", DW'(cfg_err), DW'(0));
    tick();
    reset = 1'b1;

    run_job(3, 0, 1'b1, 100, 8'h00, 0, 1'b0, 0);
    run_job(2, 0, 1'b1, 0, 8'b0001_0100, 5, 1'b0, 0);
    run_job(0, 0, 1'b1, 100, 8'h00, 0, 1'b0, 0);
    run_job(9, 0, 1'b1, 100, 8'h00, 0, 1'b0, 0);
    run_job(3, 1, 1'b0, 60, 8'h00, 0, 1'b1, 3);
    reset_mid_job();
    run_job(4, 2, 1'b1, 100, 8'h00, 0, 1'b0, 0);

    for (int j = 0; j < 30; j++) begin
      run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b0,
              int'($urandom_range(30, 100)), 8'h00, 0, 1'($urandom()), 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_dispatcher.md
TILE_DISPATCHER -- requirements
Module: tile_dispatcher

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- WIDTH, 16, bits per activation lane
- MAX_INPUT_TILES, 4, tile buffer depth (maximum tiles per job)
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job request, sampled in IDLE only
- num_input_tiles  in  4  tiles in this job, sampled with start
- wr_valid  in  1  upstream tile write valid
- wr_ready  out  1  buffer accepts a tile (FILL only)
- wr_data  in  16 x WIDTH  upstream tile, 16 lanes
- tile_valid  out  1  tile offered to the accumulator
- tile_ready  in  1  accumulator accepts the tile
- tile_data  out  16 x WIDTH  tile lanes to the accumulator activation_input
- tile_idx  out  2  index of the offered tile, width clog2(MAX_INPUT_TILES)
- tile_last  out  1  offered tile is the final tile of the job
- act_load  in  1  accumulator level: accumulation complete
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on job completion
- cfg_err  out  1  one-cycle pulse on an illegal num_input_tiles

Function
REQ-003 The FSM SHALL have exactly four states, IDLE, FILL, SEND and WAIT_ACC, with the transitions in REQ-004 to REQ-009.
REQ-004 In IDLE with start=1 and 1 <= num_input_tiles <= MAX_INPUT_TILES, the block SHALL latch n=num_input_tiles, clear wr_ptr and rd_ptr, and enter FILL on the next edge.
REQ-005 In IDLE with start=1 and num_input_tiles=0, the block SHALL stay in IDLE and pulse cfg_err for one cycle.
REQ-006 In IDLE with start=1 and num_input_tiles > MAX_INPUT_TILES, the block SHALL clamp n to MAX_INPUT_TILES, pulse cfg_err for one cycle, and enter FILL.
REQ-007 In FILL, wr_ready SHALL be 1, and each cycle with wr_valid=1 SHALL write wr_data to buffer[wr_ptr] and increment wr_ptr; the write with wr_ptr=n-1 SHALL move the FSM to SEND.
REQ-008 In SEND, outputs SHALL be driven combinationally from registered state: tile_valid=1, tile_data=buffer[rd_ptr], tile_idx=rd_ptr, tile_last=(rd_ptr==n-1).
REQ-009 A transfer SHALL occur only on a cycle with tile_valid=1 and tile_ready=1; it SHALL increment rd_ptr, or on tile_last move to WAIT_ACC.
REQ-010 While tile_valid=1 and tile_ready=0, tile_data, tile_idx and tile_last SHALL remain stable.
REQ-011 In WAIT_ACC, act_load=1 SHALL move the FSM to IDLE with done=1 for exactly that transition cycle; act_load SHALL be ignored in all other states.
REQ-012 start SHALL be ignored while busy=1, and wr_valid SHALL be ignored outside FILL.
REQ-013 When tile_valid=0, tile_data, tile_idx and tile_last SHALL be 0.
REQ-014 Minimum latency SHALL be: start edge to first tile_valid = 1+n cycles with wr_valid held high; one tile per cycle with tile_ready held high.
REQ-015 The pointers SHALL never exceed n-1, and no wrap-around SHALL occur within a job.

Reset
REQ-016 When reset=0, the block SHALL asynchronously force state=IDLE, wr_ptr=0, rd_ptr=0, n=0, wr_ready=0, tile_valid=0, tile_data=0, tile_idx=0, tile_last=0, busy=0, done=0, cfg_err=0.
REQ-017 Buffer contents need not be cleared, and no buffer value SHALL be visible on the outputs until it is rewritten by a new job.
REQ-018 Reset asserted mid-job SHALL abandon the job with no done pulse, and the block SHALL accept start on the first edge after reset deasserts.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Basic job: start with num_input_tiles=3, three consecutive writes of tiles A,B,C, tile_ready=1 -> tiles A,B,C on consecutive cycles with tile_idx 0,1,2 and tile_last only on C; act_load=1 one cycle later -> done pulses once, busy falls.
- Backpressure: n=2, tile_ready toggled 0,0,1,0,1 -> each tile held stable while tile_ready=0, each tile transferred exactly once, no duplicates or skips.
- Config errors: num_input_tiles=0 -> cfg_err pulses and the FSM stays in IDLE; num_input_tiles=9 -> cfg_err pulses, n=4, exactly 4 writes accepted and 4 tiles sent.
- Ignored inputs: start pulsed during SEND, and act_load=1 during FILL/SEND -> no state change, job completes normally with a single done pulse.
- Reset mid-job: reset asserted during SEND with rd_ptr=1 -> all outputs 0 immediately (asynchronous) and no done; new job with n=1 after release -> correct single tile with tile_last=1.
- Write gaps: n=4 with wr_valid gaps of 2 cycles -> buffer order preserved, first tile_valid one cycle after the fourth write.
